dmem_rr_arbiter: RTL and testbench

- Two-requester round-robin arbiter that shares one single-port on-chip data memory (32-bit words, 13-bit word address, 6144 words, byte enables, 1-cycle read latency) between two Avalon-MM style masters, e.g. the processor data port and a DMA/test engine.
- Sits between the masters and the memory's chipselect/write/address/byteenable/writedata/readdata interface.
- Does address range checking, routes read data back to the issuing master, and gives each master a bounded wait.

---
 rtl/dmem_rr_arbiter_pkg.sv | 28 ++
 rtl/dmem_rr_arbiter_if.sv | 33 +++
 rtl/dmem_rr_arbiter_grant.sv | 47 ++++
 rtl/dmem_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_rr_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_arb_pkg
// Brief  : Shared constants, read-return pipeline record and helper for the
//          two-master data-memory round-robin arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int   ADDR_W_DEF = 13;
    localparam int   DATA_W_DEF = 32;
    localparam int   DEPTH_DEF  = 6144;
    localparam logic MST_M0     = 1'b0;
    localparam logic MST_M1     = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
        logic oor;
    } rd_pipe_t;

    // Saturating 32-bit increment used by the optional statistics counters
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
        return (inc && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : dmem_rr_arbiter_if
// Brief  : Avalon-MM style master bundle; master drives requests, slave
//          (the arbiter) drives waitrequest and the read return.
// Rev    : 1.0  initial release
// ============================================================================
interface dmem_rr_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/dmem_rr_arbiter_grant.sv
`default_nettype none
// ============================================================================
// Module : dmem_rr_grant
// Brief  : Two-way round-robin grant (combinational) with last_grant register.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_rr_grant
    import dmem_arb_pkg::*;
(
    input  wire  clk,
    input  wire  reset,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);
    logic last_grant_q;
    logic last_grant_d;

    // No grant is issued while reset is asserted
    always_comb begin
        gnt0_o       = 1'b0;
        gnt1_o       = 1'b0;
        last_grant_d = last_grant_q;
        if (!reset) begin
            if (req0_i && req1_i) begin
                if (last_grant_q == MST_M1) gnt0_o = 1'b1;
                else                        gnt1_o = 1'b1;
            end else if (req0_i) begin
                gnt0_o = 1'b1;
            end else if (req1_i) begin
                gnt1_o = 1'b1;
            end
            if (req0_i && (!req1_i || last_grant_q == MST_M1)) begin
                last_grant_d = MST_M0;
            end else if (req1_i) begin
                last_grant_d = MST_M1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) last_grant_q <= MST_M1;
        else       last_grant_q <= last_grant_d;
    end
endmodule
`default_nettype wire

// File: rtl/dmem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dmem_rr_arbiter
// Brief  : Round-robin arbiter sharing one single-port data memory between two
//          masters; range checking and read-data routing. DMEM_ARB_STATS_EN
//          adds grant/conflict statistics counters.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_rr_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int RD_LAT = 1
) (
    input  wire                  clk,
    input  wire                  reset,
    dmem_rr_arbiter_if.slave     m0,
    dmem_rr_arbiter_if.slave     m1,
    output logic [ADDR_W-1:0]    mem_address,
    output logic [DATA_W/8-1:0]  mem_byteenable,
    output logic                 mem_chipselect,
    output logic                 mem_write,
    output logic [DATA_W-1:0]    mem_writedata,
    output logic                 mem_clken,
    input  logic [DATA_W-1:0]    mem_readdata,
`ifdef DMEM_ARB_STATS_EN
    input  logic                 stat_clr,
    output logic [31:0]          stat_grant0,
    output logic [31:0]          stat_grant1,
    output logic [31:0]          stat_conflict,
`endif
    output logic                 range_err,
    input  logic                 range_err_clr
);
    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

    generate
        if (RD_LAT != 1) begin : g_bad_rd_lat
            $error("dmem_rr_arbiter: only RD_LAT == 1 is supported");
        end
    endgenerate

    logic                w_req0;
    logic                w_req1;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_any_gnt;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic                w_sel_read;
    logic                w_sel_write;
    logic                w_oor;
    rd_pipe_t            pipe_q;
    rd_pipe_t            pipe_d;
    logic                range_err_q;
    logic                range_err_d;

    assign w_req0 = m0.read | m0.write;
    assign w_req1 = m1.read | m1.write;

    dmem_rr_grant u_grant (
        .clk    (clk),
        .reset  (reset),
        .req0_i (w_req0),
        .req1_i (w_req1),
        .gnt0_o (w_gnt0),
        .gnt1_o (w_gnt1)
    );

    assign w_any_gnt   = w_gnt0 | w_gnt1;
    assign w_sel_addr  = w_gnt1 ? m1.address : m0.address;
    assign w_sel_read  = w_gnt1 ? m1.read    : m0.read;
    assign w_sel_write = w_gnt1 ? m1.write   : m0.write;
    assign w_oor       = ({1'b0, w_sel_addr} >= C_DEPTH);

    // Idle cycles present master 0's fields with chipselect low
    assign mem_address    = w_sel_addr;
    assign mem_byteenable = w_gnt1 ? m1.byteenable : m0.byteenable;
    assign mem_writedata  = w_gnt1 ? m1.writedata  : m0.writedata;
    assign mem_chipselect = w_any_gnt & ~w_oor;
    assign mem_write      = w_any_gnt & w_sel_write & ~w_oor;
    assign mem_clken      = ~reset;

    assign m0.waitrequest = reset | (w_req0 & ~w_gnt0);
    assign m1.waitrequest = reset | (w_req1 & ~w_gnt1);

    // A read+write request is a write, so it never enters the return pipe
    always_comb begin
        pipe_d       = '0;
        pipe_d.valid = w_any_gnt & w_sel_read & ~w_sel_write;
        pipe_d.owner = w_gnt1 ? MST_M1 : MST_M0;
        pipe_d.oor   = w_oor;
    end

    assign range_err_d = (w_any_gnt & w_oor) | (range_err_q & ~range_err_clr);

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_q      <= '0;
            range_err_q <= 1'b0;
        end else begin
            pipe_q      <= pipe_d;
            range_err_q <= range_err_d;
        end
    end

    assign range_err = range_err_q;

    assign m0.readdatavalid = pipe_q.valid & (pipe_q.owner == MST_M0);
    assign m1.readdatavalid = pipe_q.valid & (pipe_q.owner == MST_M1);
    assign m0.readdata = (m0.readdatavalid && !pipe_q.oor) ? mem_readdata : '0;
    assign m1.readdata = (m1.readdatavalid && !pipe_q.oor) ? mem_readdata : '0;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_grant0_q;
    logic [31:0] stat_grant1_q;
    logic [31:0] stat_conflict_q;

    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            stat_grant0_q   <= '0;
            stat_grant1_q   <= '0;
            stat_conflict_q <= '0;
        end else begin
            stat_grant0_q   <= sat_inc(stat_grant0_q, w_gnt0);
            stat_grant1_q   <= sat_inc(stat_grant1_q, w_gnt1);
            stat_conflict_q <= sat_inc(stat_conflict_q, w_req0 & w_req1);
        end
    end

    assign stat_grant0   = stat_grant0_q;
    assign stat_grant1   = stat_grant1_q;
    assign stat_conflict = stat_conflict_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_rr_arbiter
// Brief  : Directed plus randomized bench for dmem_rr_arbiter against a
//          transaction-level reference model and a behavioural memory.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dmem_rr_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int DEPTH = 6144;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_rr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
    dmem_rr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect;
    logic          mem_write;
    logic [31:0]   mem_writedata;
    logic          mem_clken;
    logic [31:0]   mem_readdata;
    logic          range_err;
    logic          range_err_clr;
    logic          stat_clr;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0]   stat_grant0;
    logic [31:0]   stat_grant1;
    logic [31:0]   stat_conflict;
`endif

    // Master-side drive arrays, index = master number
    bit          d_rd [2];
    bit          d_wr [2];
    logic [AW-1:0] d_addr [2];
    logic [3:0]  d_be [2];
    logic [31:0] d_wd [2];

    assign m0_if.read = d_rd[0];  assign m0_if.write = d_wr[0];
    assign m0_if.address = d_addr[0];  assign m0_if.byteenable = d_be[0];
    assign m0_if.writedata = d_wd[0];
    assign m1_if.read = d_rd[1];  assign m1_if.write = d_wr[1];
    assign m1_if.address = d_addr[1];  assign m1_if.byteenable = d_be[1];
    assign m1_if.writedata = d_wd[1];

    dmem_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .m0             (m0_if),
        .m1             (m1_if),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
`ifdef DMEM_ARB_STATS_EN
        .stat_clr       (stat_clr),
        .stat_grant0    (stat_grant0),
        .stat_grant1    (stat_grant1),
        .stat_conflict  (stat_conflict),
`endif
        .range_err      (range_err),
        .range_err_clr  (range_err_clr)
    );

    // Behavioural single-port memory, 1-cycle read latency
    logic [31:0] env_mem [0:8191];
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) env_mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= env_mem[mem_address];
            end
        end
    end

    // Reference model state
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] ref_mem [0:DEPTH-1];
    int          last_win;
    bit          exp_rv [2];
    logic [31:0] exp_rd [2];
    bit          exp_rerr;
    longint      exp_sg [2];
    longint      exp_sc;
    bit          acc [2];
    logic        obs_w [2];
    logic        obs_rv [2];
    logic [31:0] obs_rd [2];
    logic        obs_cs;
    logic        obs_rerr;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic longint sat32(input longint v, input bit inc);
        return (inc && v < 64'hFFFF_FFFF) ? v + 1 : v;
    endfunction

    // One clock cycle: inputs already set at the falling edge
    task automatic step();
        int   win;
        bit   oor;
        bit   req [2];
        logic [AW-1:0] a;
        #1;
        req[0] = d_rd[0] | d_wr[0];
        req[1] = d_rd[1] | d_wr[1];
        win = -1;
        if (!reset) begin
            if (req[0] && req[1]) win = (last_win == 1) ? 0 : 1;
            else if (req[0])      win = 0;
            else if (req[1])      win = 1;
        end
        oor = (win >= 0) && (int'(d_addr[win]) >= DEPTH);

        obs_w[0] = m0_if.waitrequest;  obs_w[1] = m1_if.waitrequest;
        obs_rv[0] = m0_if.readdatavalid;  obs_rv[1] = m1_if.readdatavalid;
        obs_rd[0] = m0_if.readdata;  obs_rd[1] = m1_if.readdata;
        obs_cs = mem_chipselect;  obs_rerr = range_err;

        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("m%0d_waitrequest", m), 32'(obs_w[m]),
                     32'(reset || (req[m] && win != m)));
            check_eq($sformatf("m%0d_readdatavalid", m), 32'(obs_rv[m]), 32'(exp_rv[m]));
            check_eq($sformatf("m%0d_readdata", m), obs_rd[m], exp_rv[m] ? exp_rd[m] : 32'h0);
        end
        check_eq("mem_chipselect", 32'(obs_cs), 32'(win >= 0 && !oor));
        check_eq("mem_write", 32'(mem_write), 32'(win >= 0 && !oor && d_wr[win]));
        check_eq("mem_clken", 32'(mem_clken), 32'(!reset));
        check_eq("range_err", 32'(obs_rerr), 32'(exp_rerr));
        if (win >= 0 && !oor) begin
            check_eq("mem_address", 32'(mem_address), 32'(d_addr[win]));
            if (d_wr[win]) begin
                check_eq("mem_byteenable", 32'(mem_byteenable), 32'(d_be[win]));
                check_eq("mem_writedata", mem_writedata, d_wd[win]);
            end
        end
`ifdef DMEM_ARB_STATS_EN
        check_eq("stat_grant0", stat_grant0, 32'(exp_sg[0]));
        check_eq("stat_grant1", stat_grant1, 32'(exp_sg[1]));
        check_eq("stat_conflict", stat_conflict, 32'(exp_sc));
`endif

        // Advance the model across the rising edge
        acc[0] = 1'b0;  acc[1] = 1'b0;
        exp_rv[0] = 1'b0;  exp_rv[1] = 1'b0;
        if (win >= 0) begin
            acc[win] = 1'b1;
            last_win = win;
            a = d_addr[win];
            if (d_wr[win]) begin
                if (!oor)
                    for (int b = 0; b < 4; b++)
                        if (d_be[win][b]) ref_mem[a][8*b +: 8] = d_wd[win][8*b +: 8];
            end else begin
                exp_rv[win] = 1'b1;
                exp_rd[win] = oor ? 32'h0 : ref_mem[a];
            end
        end
        if (reset)              exp_rerr = 1'b0;
        else if (oor)           exp_rerr = 1'b1;
        else if (range_err_clr) exp_rerr = 1'b0;
        if (reset || stat_clr) begin
            exp_sg[0] = 0;  exp_sg[1] = 0;  exp_sc = 0;
        end else begin
            exp_sg[0] = sat32(exp_sg[0], win == 0);
            exp_sg[1] = sat32(exp_sg[1], win == 1);
            exp_sc    = sat32(exp_sc, req[0] && req[1]);
        end
        if (reset) begin
            last_win = 1;
            exp_rv[0] = 1'b0;  exp_rv[1] = 1'b0;
        end

        @(negedge clk);
        for (int m = 0; m < 2; m++)
            if (acc[m]) begin d_rd[m] = 1'b0; d_wr[m] = 1'b0; end
    endtask

    task automatic issue(input int m, input bit wr, input bit rd, input logic [AW-1:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        d_rd[m] = rd;  d_wr[m] = wr;  d_addr[m] = a;  d_be[m] = be;  d_wd[m] = wd;
        for (int i = 0; i < 8 && (d_rd[m] || d_wr[m]); i++) step();
        check_eq("accept_bound", 32'(d_rd[m] || d_wr[m]), 32'h0);
        d_rd[m] = 1'b0;  d_wr[m] = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) step();
        reset = 1'b0;
    endtask

    task automatic contend(input int n);
        for (int i = 0; i < n; i++) begin
            if (!d_rd[0]) begin d_rd[0] = 1'b1; d_addr[0] = AW'(i); end
            if (!d_rd[1]) begin d_rd[1] = 1'b1; d_addr[1] = AW'(200 + i); end
            step();
            check_eq("cont_wait0", 32'(obs_w[0]), 32'(i % 2));
            check_eq("cont_wait1", 32'(obs_w[1]), 32'((i + 1) % 2));
            check_eq("cont_rv0", 32'(obs_rv[0]), 32'(i % 2 == 1));
            check_eq("cont_rv1", 32'(obs_rv[1]), 32'(i > 0 && i % 2 == 0));
        end
        d_rd[0] = 1'b0;  d_rd[1] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            env_mem[i] = $urandom;
            if (i < DEPTH) ref_mem[i] = env_mem[i];
        end
        for (int m = 0; m < 2; m++) begin
            d_rd[m] = 0; d_wr[m] = 0; d_addr[m] = '0; d_be[m] = '0; d_wd[m] = '0;
            exp_rv[m] = 0; exp_rd[m] = '0; exp_sg[m] = 0; acc[m] = 0;
        end
        exp_sc = 0;  exp_rerr = 0;  last_win = 1;
        range_err_clr = 1'b0;  stat_clr = 1'b0;  mem_readdata = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        do_reset(2);
        step();

        // Single master write then read
        issue(0, 1, 0, 13'h0010, 4'hF, 32'hA5A5_0001);
        check_eq("single_wr_wait", 32'(obs_w[0]), 32'h0);
        issue(0, 0, 1, 13'h0010, 4'hF, 32'h0);
        check_eq("single_rd_wait", 32'(obs_w[0]), 32'h0);
        step();
        check_eq("single_rdv0", 32'(obs_rv[0]), 32'h1);
        check_eq("single_rdata", obs_rd[0], 32'hA5A5_0001);
        check_eq("single_rdv1", 32'(obs_rv[1]), 32'h0);

        // Contention from reset
        do_reset(1);
        contend(6);
        step();

        // Byte enables
        issue(0, 1, 0, 13'h0020, 4'hF, 32'hFFFF_FFFF);
        issue(0, 1, 0, 13'h0020, 4'h5, 32'h1234_5678);
        issue(0, 0, 1, 13'h0020, 4'hF, 32'h0);
        step();
        check_eq("be_rdata", obs_rd[0], 32'hFF34_FF78);

        // Out of range from master 1
        issue(1, 1, 0, 13'd6144, 4'hF, 32'hDEAD_BEEF);
        check_eq("oor_wr_wait", 32'(obs_w[1]), 32'h0);
        check_eq("oor_wr_cs", 32'(obs_cs), 32'h0);
        issue(1, 0, 1, 13'd8191, 4'hF, 32'h0);
        check_eq("oor_rd_cs", 32'(obs_cs), 32'h0);
        step();
        check_eq("oor_rdv", 32'(obs_rv[1]), 32'h1);
        check_eq("oor_rdata", obs_rd[1], 32'h0);
        check_eq("oor_err_set", 32'(obs_rerr), 32'h1);
        step();
        check_eq("oor_err_hold", 32'(obs_rerr), 32'h1);
        range_err_clr = 1'b1;
        step();
        range_err_clr = 1'b0;
        step();
        check_eq("oor_err_clr", 32'(obs_rerr), 32'h0);

        // Reset together with a read request
        d_rd[0] = 1'b1;  d_addr[0] = 13'h0010;
        reset = 1'b1;
        step();
        check_eq("rst_wait0", 32'(obs_w[0]), 32'h1);
        reset = 1'b0;
        d_rd[1] = 1'b1;  d_addr[1] = 13'h0011;
        step();
        check_eq("rst_no_rdv0", 32'(obs_rv[0]), 32'h0);
        check_eq("rst_no_rdv1", 32'(obs_rv[1]), 32'h0);
        check_eq("rst_first_m0", 32'(obs_w[0]), 32'h0);
        check_eq("rst_first_m1", 32'(obs_w[1]), 32'h1);
        repeat (3) step();

`ifdef DMEM_ARB_STATS_EN
        do_reset(1);
        contend(10);
        check_eq("stat_g0_10", stat_grant0, 32'd5);
        check_eq("stat_g1_10", stat_grant1, 32'd5);
        check_eq("stat_conf_10", stat_conflict, 32'd10);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        check_eq("stat_g0_clr", stat_grant0, 32'd0);
        check_eq("stat_g1_clr", stat_grant1, 32'd0);
        check_eq("stat_conf_clr", stat_conflict, 32'd0);
`endif

        // Randomized traffic
        for (int c = 0; c < 500; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!(d_rd[m] || d_wr[m]) && $urandom_range(0, 99) < 65) begin
                    int k;
                    k = $urandom_range(0, 3);
                    d_rd[m]   = (k != 2);
                    d_wr[m]   = (k >= 2);
                    d_addr[m] = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, 8191))
                                                            : AW'($urandom_range(0, 63));
                    d_be[m]   = 4'($urandom);
                    d_wd[m]   = $urandom;
                end
            end
            range_err_clr = ($urandom_range(0, 7) == 0);
            stat_clr      = ($urandom_range(0, 49) == 0);
            reset         = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;  range_err_clr = 1'b0;  stat_clr = 1'b0;
        d_rd[0] = 0; d_wr[0] = 0; d_rd[1] = 0; d_wr[1] = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
